// File: rtl/ccg_resp_pkg.sv
// Shared constants, state encoding and group-consistency helper for the
// combinational-benchmark response compactor.
package ccg_resp_pkg;

    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    // Bit i-1 of the response word carries f<i>.
    // A = f1..f7, f12, f14, f15 ; B = f8..f11, f13, f16, f17
    localparam logic [16:0] GROUP_A_MASK = 17'h0687F;
    localparam logic [16:0] GROUP_B_MASK = 17'h19780;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A group is consistent when every member equals the group's reference bit.
    function automatic logic group_violation(input logic [16:0] f,
                                             input logic [16:0] mask,
                                             input logic        ref_bit);
        return (f & mask) != (ref_bit ? mask : 17'd0);
    endfunction

endpackage

// File: rtl/ccg_misr32.sv
// 32-bit multiple-input signature register folding a 17-bit response per beat.
module ccg_misr32
    import ccg_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [16:0] din,
    output logic [31:0] sig
);

    logic [31:0] sig_q, sig_d;

    // load wins over en so a new run always begins from SEED.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'd0) ^ {15'd0, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/ccg_resp_compactor.sv
// Captures a run of benchmark response vectors: MISR signature, f1/f8 ones
// counts and output-group consistency statistics.
module ccg_resp_compactor
    import ccg_resp_pkg::*;
#(
    parameter int NVEC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NVEC_W-1:0] num_vec,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16:0]       in_f,
    output logic [31:0]       sig,
    output logic [NVEC_W-1:0] ones_f1,
    output logic [NVEC_W-1:0] ones_f8,
    output logic [NVEC_W-1:0] mismatch_cnt,
    output logic [NVEC_W-1:0] first_err_idx,
    output logic              err_flag,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    // Handshake: a beat transfers on a rising clk edge where in_valid and
    // in_ready are both 1; in_ready is high exactly while in RUN.

    state_t            state_q, state_d;
    logic [1:0]        rst_sync_q;
    logic [NVEC_W-1:0] nvec_q, nvec_d;
    logic [NVEC_W-1:0] idx_q, idx_d;
    logic [NVEC_W-1:0] f1_q, f1_d;
    logic [NVEC_W-1:0] f8_q, f8_d;
    logic [NVEC_W-1:0] mis_q, mis_d;
    logic [NVEC_W-1:0] first_q, first_d;
    logic              err_q, err_d;

    logic start_acc, beat, last_beat, viol;

    // start stays blocked until reset release has passed two clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign start_acc = start && rst_sync_q[1] && (state_q != ST_RUN);
    assign beat      = (state_q == ST_RUN) && in_valid;
    assign last_beat = beat && (idx_q == nvec_q - 1'b1);
    assign viol      = group_violation(in_f, GROUP_A_MASK, in_f[0]) |
                       group_violation(in_f, GROUP_B_MASK, in_f[7]);

    always_comb begin
        state_d = state_q;
        nvec_d  = nvec_q;
        idx_d   = idx_q;
        f1_d    = f1_q;
        f8_d    = f8_q;
        mis_d   = mis_q;
        first_d = first_q;
        err_d   = err_q;
        if (start_acc) begin
            nvec_d  = num_vec;
            idx_d   = '0;
            f1_d    = '0;
            f8_d    = '0;
            mis_d   = '0;
            first_d = '0;
            err_d   = 1'b0;
            state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
        end else if (beat) begin
            idx_d = idx_q + 1'b1;
            f1_d  = f1_q + {{(NVEC_W-1){1'b0}}, in_f[0]};
            f8_d  = f8_q + {{(NVEC_W-1){1'b0}}, in_f[7]};
            if (viol) begin
                mis_d = mis_q + 1'b1;
                if (!err_q) begin
                    first_d = idx_q;
                    err_d   = 1'b1;
                end
            end
            if (last_beat) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            nvec_q  <= '0;
            idx_q   <= '0;
            f1_q    <= '0;
            f8_q    <= '0;
            mis_q   <= '0;
            first_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nvec_q  <= nvec_d;
            idx_q   <= idx_d;
            f1_q    <= f1_d;
            f8_q    <= f8_d;
            mis_q   <= mis_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    ccg_misr32 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .en    (beat),
        .din   (in_f),
        .sig   (sig)
    );

    assign in_ready      = (state_q == ST_RUN);
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign ones_f1       = f1_q;
    assign ones_f8       = f8_q;
    assign mismatch_cnt  = mis_q;
    assign first_err_idx = first_q;
    assign err_flag      = err_q;
    assign dbg_state     = state_q;

endmodule
